piano_key_encoder: RTL and testbench



---
 rtl/piano_key_encoder_pkg.sv | 38 +++
 rtl/piano_key_encoder_checker.sv | 22 ++
 rtl/piano_key_encoder_key_debounce.sv | 44 ++++
 rtl/piano_key_encoder.sv | 71 +++++++
 tb/tb_piano_key_encoder.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/piano_key_encoder_pkg.sv
// Shared note codes and key-encoding helpers for the piano front end.
// Codes match the ones the song-tutor FSMs and tone generator expect.
package piano_key_encoder_pkg;

  localparam int NUM_KEYS = 8;

  typedef enum logic [3:0] {
    NOTE_NONE = 4'd0,
    NOTE_C4   = 4'd1,
    NOTE_D    = 4'd2,
    NOTE_E    = 4'd3,
    NOTE_F    = 4'd4,
    NOTE_G    = 4'd5,
    NOTE_A    = 4'd6,
    NOTE_B    = 4'd7,
    NOTE_C5   = 4'd8
  } note_t;

  // Lowest-index pressed key wins, so C4 has the highest priority.
  function automatic note_t encode_note(input logic [NUM_KEYS-1:0] keys);
    note_t code;
    code = NOTE_NONE;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (keys[i]) begin
        code = note_t'(4'(i) + 4'd1);
      end else begin
        code = code;
      end
    end
    return code;
  endfunction

  // True when two or more keys are set (clearing the lowest set bit leaves something).
  function automatic logic is_chord(input logic [NUM_KEYS-1:0] keys);
    return ((keys & (keys - 8'd1)) != 8'd0);
  endfunction

endpackage

// File: rtl/piano_key_encoder_checker.sv
// Protocol checks on the encoder outputs, kept apart from the datapath.
module piano_key_encoder_checker
  import piano_key_encoder_pkg::*;
(
  input logic                CLK,
  input logic                RESET,
  input logic [3:0]          note,
  input logic                note_strobe,
  input logic [NUM_KEYS-1:0] key_db
);

  // A strobe always marks the start of a real, different note.
  a_strobe_not_none : assert property (@(posedge CLK) disable iff (RESET)
    note_strobe |-> (note != 4'(NOTE_NONE)));

  a_strobe_on_change : assert property (@(posedge CLK) disable iff (RESET)
    note_strobe |-> (note != $past(note)));

  a_note_needs_key : assert property (@(posedge CLK) disable iff (RESET)
    (note != 4'(NOTE_NONE)) |-> ($past(key_db) != 8'd0));

endmodule

// File: rtl/piano_key_encoder_key_debounce.sv
// One key: two-flop synchroniser followed by a stable-level debounce counter.
// The counter only runs while the synchronised level disagrees with the accepted one.
module piano_key_encoder_key_debounce #(
  parameter int DEBOUNCE_CNT = 500000,
  parameter int CNT_W        = 20
) (
  input  logic CLK,
  input  logic RESET,
  input  logic key_in,
  output logic key_db
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_r;
  logic             sync2_r;
  logic             level_r;
  logic [CNT_W-1:0] cnt_r;

  // Synchronise the raw pin and accept a new level once it has held for DEBOUNCE_CNT cycles.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      level_r <= 1'b0;
      cnt_r   <= '0;
    end else begin
      sync1_r <= key_in;
      sync2_r <= sync1_r;
      if (sync2_r == level_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CNT_LAST) begin
        level_r <= sync2_r;
        cnt_r   <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  assign key_db = level_r;

endmodule

// File: rtl/piano_key_encoder.sv
// Piano key front end: eight debounced keys priority-encoded into a registered note code.
// Define CHORD_REJECT_EN to report none while more than one key is held.
module piano_key_encoder
  import piano_key_encoder_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 500000,
  parameter int CNT_W        = 20
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [3:0]          note,
  output logic                note_strobe,
  output logic [NUM_KEYS-1:0] key_db
);

  logic [NUM_KEYS-1:0] key_db_s;
  note_t               next_note_s;
  note_t               note_r;
  logic                note_strobe_r;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    piano_key_encoder_key_debounce #(
      .DEBOUNCE_CNT(DEBOUNCE_CNT),
      .CNT_W       (CNT_W)
    ) u_key_debounce (
      .CLK   (CLK),
      .RESET (RESET),
      .key_in(key_in[k]),
      .key_db(key_db_s[k])
    );
  end

  // Combinational encoder from the debounced key levels.
  always_comb begin
    next_note_s = NOTE_NONE;
`ifdef CHORD_REJECT_EN
    if (is_chord(key_db_s)) begin
      next_note_s = NOTE_NONE;
    end else begin
      next_note_s = encode_note(key_db_s);
    end
`else
    next_note_s = encode_note(key_db_s);
`endif
  end

  // Register the note and pulse the strobe when a new non-none note begins.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      note_r        <= NOTE_NONE;
      note_strobe_r <= 1'b0;
    end else begin
      note_r        <= next_note_s;
      note_strobe_r <= (next_note_s != NOTE_NONE) && (next_note_s != note_r);
    end
  end

  assign note        = note_r;
  assign note_strobe = note_strobe_r;
  assign key_db      = key_db_s;

  piano_key_encoder_checker u_checker (
    .CLK        (CLK),
    .RESET      (RESET),
    .note       (note),
    .note_strobe(note_strobe),
    .key_db     (key_db)
  );

endmodule

// File: tb/tb_piano_key_encoder.sv
// Directed bench for piano_key_encoder with a short debounce window (4 cycles).
module tb_piano_key_encoder;

  logic       CLK;
  logic       RESET;
  logic [7:0] key_in;
  logic [3:0] note;
  logic       note_strobe;
  logic [7:0] key_db;

  int vectors     = 0;
  int miscompares = 0;

  piano_key_encoder #(
    .DEBOUNCE_CNT(4),
    .CNT_W       (3)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .key_in     (key_in),
    .note       (note),
    .note_strobe(note_strobe),
    .key_db     (key_db)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] exp_note, input logic exp_strobe);
    check({tag, ".note"}, {4'd0, note}, {4'd0, exp_note});
    check({tag, ".strobe"}, {7'd0, note_strobe}, {7'd0, exp_strobe});
  endtask

  initial begin
    RESET  = 1'b1;
    key_in = 8'hFF;
    tick(2);
    check_out("reset", 4'd0, 1'b0);
    check("reset.key_db", key_db, 8'h00);

    // All keys held through reset release: edge 0 is the first sample.
    RESET = 1'b0;
    tick(5);
    check("rel.key_db_e4", key_db, 8'h00);
    tick(1);
    check("rel.key_db_e5", key_db, 8'hFF);
    check_out("rel.e5", 4'd0, 1'b0);
    tick(1);
    check_out("rel.e6", 4'd1, 1'b1);
    tick(1);
    check_out("rel.e7", 4'd1, 1'b0);
    key_in = 8'h00;
    tick(8);
    check_out("rel.off", 4'd0, 1'b0);

    // Clean press of E.
    key_in = 8'h04;
    tick(6);
    check("press.key_db", key_db, 8'h04);
    check_out("press.e5", 4'd0, 1'b0);
    tick(1);
    check_out("press.e6", 4'd3, 1'b1);
    tick(1);
    check_out("press.e7", 4'd3, 1'b0);
    key_in = 8'h00;
    tick(6);
    check_out("unpress.e5", 4'd3, 1'b0);
    tick(1);
    check_out("unpress.e6", 4'd0, 1'b0);
    tick(2);

    // Bouncing F: pulses of two cycles never qualify.
    for (int i = 0; i < 2; i++) begin
      key_in = 8'h08;
      tick(2);
      check("bounce.hi.key_db", key_db, 8'h00);
      key_in = 8'h00;
      tick(2);
      check_out("bounce.lo", 4'd0, 1'b0);
    end
    key_in = 8'h08;
    tick(6);
    check_out("bounce.e5", 4'd0, 1'b0);
    tick(1);
    check_out("bounce.e6", 4'd4, 1'b1);
    key_in = 8'h00;
    tick(9);
    check_out("bounce.off", 4'd0, 1'b0);

    // Priority: G held, D added then released.
    key_in = 8'h10;
    tick(7);
    check_out("prio.g", 4'd5, 1'b1);
    tick(1);
    key_in = 8'h12;
    tick(6);
    check_out("prio.gd.e5", 4'd5, 1'b0);
    tick(1);
    check_out("prio.gd.e6", 4'd2, 1'b1);
    tick(1);
    check_out("prio.gd.e7", 4'd2, 1'b0);
    key_in = 8'h10;
    tick(7);
    check_out("prio.back_g", 4'd5, 1'b1);
    key_in = 8'h00;
    tick(9);
    check_out("prio.off", 4'd0, 1'b0);

    // Reset while E's counter is at 2; full requalification afterwards.
    key_in = 8'h04;
    tick(4);
    RESET = 1'b1;
    tick(1);
    check("mid.key_db", key_db, 8'h00);
    check_out("mid.reset", 4'd0, 1'b0);
    RESET = 1'b0;
    tick(5);
    check("mid.key_db_e4", key_db, 8'h00);
    check_out("mid.e4", 4'd0, 1'b0);
    tick(1);
    check("mid.key_db_e5", key_db, 8'h04);
    tick(1);
    check_out("mid.e6", 4'd3, 1'b1);
    key_in = 8'h00;
    tick(9);
    check_out("mid.off", 4'd0, 1'b0);

    // C4 and A qualify on the same cycle, then A is released.
    key_in = 8'h21;
    tick(6);
    check("chord.key_db", key_db, 8'h21);
    tick(1);
`ifdef CHORD_REJECT_EN
    check_out("chord.e6", 4'd0, 1'b0);
    tick(1);
    check_out("chord.e7", 4'd0, 1'b0);
    key_in = 8'h01;
    tick(7);
    check_out("chord.resolve", 4'd1, 1'b1);
`else
    check_out("chord.e6", 4'd1, 1'b1);
    tick(1);
    check_out("chord.e7", 4'd1, 1'b0);
    key_in = 8'h01;
    tick(7);
    check_out("chord.resolve", 4'd1, 1'b0);
`endif
    tick(1);
    check_out("chord.hold", 4'd1, 1'b0);
    key_in = 8'h00;
    tick(9);
    check_out("chord.off", 4'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
